divider_unit: RTL and testbench

Parametrised multi-cycle restoring divider that supports both signed and unsigned operands. It uses a start/finished handshake with an explicit busy flag. Operands are captured at start and results are held until the next operation. It handles divide-by-zero (with early finish) and the signed-overflow case deterministically. It sits beside the ALU as the shared integer divide resource.

---
 rtl/divider_unit.sv | 131 +++++++++++++
 tb/tb_divider_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Multi-cycle restoring divider (signed or unsigned) with a start/finished handshake.
// Operands are captured on the accepting edge. Divide-by-zero skips straight to DONE.
// Results and flags stay in their registers until the next operation writes them.
module divider_unit #(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_signed,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_finished,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_undefined,
  output logic         o_overflow
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [N-1:0]  dvd_shift_reg;   // dividend magnitude, consumed MSB first
  logic [N-1:0]  dvs_reg;         // divisor magnitude
  logic [N-1:0]  quo_reg;
  logic [N-1:0]  rem_reg;
  logic          neg_quo_reg;
  logic          neg_rem_reg;
  logic          ovf_pending_reg;

  logic          accept;
  logic          zero_div;
  logic          last_step;
  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
  logic [N:0]    rem_shift;
  logic [N-1:0]  trial;
  logic          no_borrow;

  assign accept    = i_start && ((state_reg == IDLE) || (state_reg == DONE));
  assign zero_div  = (i_divisor == '0);
  assign last_step = (count_reg == CW'(N - 1));

  // |-2^(N-1)| wraps to the 2^(N-1) bit pattern, which is exactly the unsigned magnitude.
  assign dvd_mag = (i_signed && i_dividend[N-1]) ? -i_dividend : i_dividend;
  assign dvs_mag = (i_signed && i_divisor[N-1])  ? -i_divisor  : i_divisor;

  // The N+1-bit shifted remainder is compared against the divisor, which is the
  // no-borrow test. When it succeeds the difference is below the divisor, so the
  // low N bits of the subtraction hold it exactly.
  assign rem_shift = {rem_reg, dvd_shift_reg[N-1]};
  assign no_borrow = (rem_shift >= {1'b0, dvs_reg});
  assign trial     = rem_shift[N-1:0] - dvs_reg;

  assign o_busy     = (state_reg == DIVIDE) || (state_reg == FIXUP);
  assign o_finished = (state_reg == DONE);

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (accept)                 state_next = zero_div ? DONE : DIVIDE;
        else if (state_reg == DONE) state_next = IDLE;
      end
      DIVIDE:  if (last_step) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, restoring steps and the result write.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count_reg       <= '0;
      dvd_shift_reg   <= '0;
      dvs_reg         <= '0;
      quo_reg         <= '0;
      rem_reg         <= '0;
      neg_quo_reg     <= 1'b0;
      neg_rem_reg     <= 1'b0;
      ovf_pending_reg <= 1'b0;
      o_quotient      <= '0;
      o_remainder     <= '0;
      o_undefined     <= 1'b0;
      o_overflow      <= 1'b0;
    end else if (accept) begin
      count_reg       <= '0;
      dvd_shift_reg   <= dvd_mag;
      dvs_reg         <= dvs_mag;
      quo_reg         <= '0;
      rem_reg         <= '0;
      neg_quo_reg     <= i_signed && (i_dividend[N-1] ^ i_divisor[N-1]);
      neg_rem_reg     <= i_signed && i_dividend[N-1];
      ovf_pending_reg <= i_signed && (i_dividend == {1'b1, {(N-1){1'b0}}}) && (&i_divisor);
      if (zero_div) begin
        o_quotient  <= '1;
        o_remainder <= i_dividend;
        o_undefined <= 1'b1;
        o_overflow  <= 1'b0;
      end
    end else begin
      case (state_reg)
        DIVIDE: begin
          count_reg     <= count_reg + CW'(1);
          dvd_shift_reg <= {dvd_shift_reg[N-2:0], 1'b0};
          rem_reg       <= no_borrow ? trial : rem_shift[N-1:0];
          quo_reg       <= {quo_reg[N-2:0], no_borrow};
        end
        FIXUP: begin
          o_quotient  <= neg_quo_reg ? -quo_reg : quo_reg;
          o_remainder <= neg_rem_reg ? -rem_reg : rem_reg;
          o_undefined <= 1'b0;
          o_overflow  <= ovf_pending_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: an 8-bit instance covers the arithmetic, latency
// and reset cases, and a 16-bit instance covers back-to-back operation.
module tb_divider_unit;

  logic        clk;
  logic        rst;

  logic        start8, sgn8, busy8, fin8, und8, ovf8;
  logic [7:0]  dvd8, dvs8, q8, r8;

  logic        start16, sgn16, busy16, fin16, und16, ovf16;
  logic [15:0] dvd16, dvs16, q16, r16;

  int n_checks = 0;
  int n_fail   = 0;

  divider_unit #(.N(8)) dut8 (
    .i_clock(clk), .i_reset(rst), .i_start(start8), .i_signed(sgn8),
    .i_dividend(dvd8), .i_divisor(dvs8), .o_busy(busy8), .o_finished(fin8),
    .o_quotient(q8), .o_remainder(r8), .o_undefined(und8), .o_overflow(ovf8)
  );

  divider_unit #(.N(16)) dut16 (
    .i_clock(clk), .i_reset(rst), .i_start(start16), .i_signed(sgn16),
    .i_dividend(dvd16), .i_divisor(dvs16), .o_busy(busy16), .o_finished(fin16),
    .o_quotient(q16), .o_remainder(r16), .o_undefined(und16), .o_overflow(ovf16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One 8-bit operation. The operands are scrambled right after the accepting edge.
  // Then latency (samples after edge 0), busy cycles, results and the pulse width are checked.
  task automatic op8(input string tag, input logic sgn, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] eq, input logic [7:0] er,
                     input logic eu, input logic eo, input int elat);
    int lat;
    int busy_cnt;
    lat = -1;
    busy_cnt = 0;
    @(negedge clk);
    sgn8 = sgn; dvd8 = a; dvs8 = b; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; dvd8 = ~a; dvs8 = ~b; sgn8 = ~sgn;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
      if (fin8) begin
        lat = k;
        break;
      end
    end
    $display("op %s: sgn=%0d 0x%02h/0x%02h -> q=0x%02h r=0x%02h und=%0d ovf=%0d lat=%0d",
             tag, sgn, a, b, q8, r8, und8, ovf8, lat);
    check_value({tag, " latency"}, 32'(lat), 32'(elat));
    check_value({tag, " busy"}, 32'(busy_cnt), 32'(elat));
    check_value({tag, " q"}, 32'(q8), 32'(eq));
    check_value({tag, " r"}, 32'(r8), 32'(er));
    check_value({tag, " und"}, 32'(und8), 32'(eu));
    check_value({tag, " ovf"}, 32'(ovf8), 32'(eo));
    @(negedge clk);
    check_value({tag, " pulse end"}, 32'(fin8), 32'd0);
    check_value({tag, " q held"}, 32'(q8), 32'(eq));
  endtask

  initial begin
    int lat;
    int fin_cnt;
    int k1;
    int k2;

    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; dvd8 = '0; dvs8 = '0;
    start16 = 1'b0; sgn16 = 1'b0; dvd16 = '0; dvs16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("reset q", 32'(q8), 32'd0);
    check_value("reset r", 32'(r8), 32'd0);
    check_value("reset flags", 32'({busy8, fin8, und8, ovf8}), 32'd0);
    rst = 1'b0;

    op8("u200/7",  1'b0, 8'd200, 8'd7,  8'h1C, 8'h04, 1'b0, 1'b0, 9);
    op8("s-7/2",   1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 9);
    op8("s7/-2",   1'b1, 8'h07,  8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 9);
    op8("u55/0",   1'b0, 8'h55,  8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 0);
    op8("s55/0",   1'b1, 8'h55,  8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 0);
    op8("s85/0",   1'b1, 8'h85,  8'h00, 8'hFF, 8'h85, 1'b1, 1'b0, 0);
    op8("u80/FF",  1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 9);
    op8("s80/FF",  1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9);
    op8("u255/1",  1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9);

    // Asynchronous reset in the middle of DIVIDE, away from any clock edge.
    op8("s-128/3", 1'b1, 8'h80,  8'h03, 8'hD6, 8'hFE, 1'b0, 1'b0, 9);
    @(negedge clk);
    sgn8 = 1'b0; dvd8 = 8'd200; dvs8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_value("async rst busy", 32'(busy8), 32'd0);
    check_value("async rst q", 32'(q8), 32'd0);
    check_value("async rst r", 32'(r8), 32'd0);
    check_value("async rst fin/und/ovf", 32'({fin8, und8, ovf8}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fin_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (fin8) fin_cnt++;
    end
    $display("op abort: reset during DIVIDE, finished pulses afterwards=%0d", fin_cnt);
    check_value("abort no finished", 32'(fin_cnt), 32'd0);

    // 9/3 with stray start pulses during DIVIDE that must be ignored and not queued.
    @(negedge clk);
    sgn8 = 1'b0; dvd8 = 8'd9; dvs8 = 8'd3; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd10;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (fin8) begin
        lat = k;
        break;
      end
      start8 = (k == 2 || k == 5);
    end
    start8 = 1'b0;
    $display("op u9/3: q=0x%02h r=0x%02h lat=%0d", q8, r8, lat);
    check_value("u9/3 latency", 32'(lat), 32'd9);
    check_value("u9/3 q", 32'(q8), 32'd3);
    check_value("u9/3 r", 32'(r8), 32'd0);
    fin_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (fin8) fin_cnt++;
    end
    check_value("ignored start not queued", 32'(fin_cnt), 32'd0);

    // 16-bit back-to-back: i_start is held through DONE so the second op follows at once.
    @(negedge clk);
    sgn16 = 1'b0; dvd16 = 16'd65535; dvs16 = 16'd255; start16 = 1'b1;
    @(posedge clk);
    #1;
    dvd16 = 16'd1000; dvs16 = 16'd33;
    k1 = -1;
    k2 = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (fin16) begin
        if (k1 < 0) begin
          k1 = k;
          $display("op b2b first: 65535/255 -> q=%0d r=%0d at sample %0d", q16, r16, k);
          check_value("b2b1 q", 32'(q16), 32'd257);
          check_value("b2b1 r", 32'(r16), 32'd0);
          @(posedge clk);
          #1 start16 = 1'b0;
        end else begin
          k2 = k;
          $display("op b2b second: 1000/33 -> q=%0d r=%0d at sample %0d", q16, r16, k);
          check_value("b2b2 q", 32'(q16), 32'd30);
          check_value("b2b2 r", 32'(r16), 32'd10);
          break;
        end
      end
    end
    start16 = 1'b0;
    check_value("b2b1 latency", 32'(k1), 32'd17);
    check_value("b2b2 latency", 32'(k2), 32'd35);
    check_value("b2b spacing", 32'(k2 - k1), 32'd18);
    check_value("b2b flags", 32'({und16, ovf16}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
